// File: rtl/fence_sequencer_pkg.sv
// Shared types and helpers for the memory-stage fence sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fence_sequencer_pkg;

   localparam int unsigned FENCE_TIMEOUT_DEFAULT = 1023;

   typedef enum logic [2:0] {
      IDLE,
      DRAIN,
      DFLUSH,
      IINV,
      TLB,
      DONE,
      ABORT
   } fence_state_t;

   typedef enum logic [1:0] {
      FENCE,
      FENCEI,
      SFENCEVMA
   } fence_kind_t;

   // FENCE.I outranks SFENCE.VMA, which outranks FENCE. FENCE is the
   // fall-through, so only the two higher-ranked opcodes are inspected.
   function automatic fence_kind_t decode_kind(input logic fencei, input logic sfencevma);
      fence_kind_t kind;
      if (fencei)
         kind = FENCEI;
      else if (sfencevma)
         kind = SFENCEVMA;
      else
         kind = FENCE;
      return kind;
   endfunction

   // Counter width able to hold the value 'limit' itself (the saturation point).
   function automatic int unsigned wd_width(input int unsigned limit);
      return (limit < 2) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/fence_sequencer_if.sv
// Pipeline <-> fence sequencer signal bundle (M-stage fence control).
// Latency: n/a (wires only).
// Backpressure: n/a; stall is carried as FenceStallM toward the hazard unit.
// master: pipeline/hazard/cache side (drives opcodes, trap, stalls, LSU/D$ status).
// slave : fence sequencer (drives cache/TLB requests, stall cause, done, timeout).
interface fence_sequencer_if;
   logic FenceM;
   logic FenceIM;
   logic SFenceVmaM;
   logic TrapM;
   logic StallW;
   logic LSUBusyM;
   logic DCacheFlushDoneM;
   logic FlushDCacheM;
   logic InvalidateICacheM;
   logic FlushTLBM;
   logic FenceStallM;
   logic FenceDoneM;
   logic FenceTimeoutM;

   modport master (
      output FenceM, FenceIM, SFenceVmaM, TrapM, StallW, LSUBusyM, DCacheFlushDoneM,
      input  FlushDCacheM, InvalidateICacheM, FlushTLBM, FenceStallM, FenceDoneM,
             FenceTimeoutM
   );

   modport slave (
      input  FenceM, FenceIM, SFenceVmaM, TrapM, StallW, LSUBusyM, DCacheFlushDoneM,
      output FlushDCacheM, InvalidateICacheM, FlushTLBM, FenceStallM, FenceDoneM,
             FenceTimeoutM
   );
endinterface

// File: rtl/fence_watchdog.sv
// Saturating per-state cycle counter that flags when a wait has run too long.
// Latency: expire_o is combinational, high in the TIMEOUT-th enabled cycle since clear.
// Backpressure: none; counts whenever en_i is high, holds otherwise.
// Ports: clk/reset, clr_i (zero on next edge), en_i (count), expire_o.
module fence_watchdog
   import fence_sequencer_pkg::*;
#(
   parameter int unsigned TIMEOUT = FENCE_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned W = wd_width(TIMEOUT);
   typedef logic [W-1:0] cnt_t;

   localparam cnt_t LIMIT = cnt_t'(TIMEOUT);
   localparam cnt_t LAST  = cnt_t'(TIMEOUT - 1);

   cnt_t cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && (cnt_q != LIMIT))
         cnt_d = cnt_q + cnt_t'(1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // The counter holds the number of cycles already spent in the state, so
   // the current cycle is the TIMEOUT-th one once it shows TIMEOUT-1.
   assign expire_o = en_i && (cnt_q >= LAST);

endmodule

// File: rtl/fence_sequencer.sv
// Sequences FENCE / FENCE.I / SFENCE.VMA: drain LSU, flush D$, invalidate I$ / flush TLB.
// Latency: stall from the detect cycle through the last side-effect state; one-cycle done after.
// Backpressure: holds M via FenceStallM; DONE waits out StallW with FenceDoneM held high.
// Ports: clk, reset (sync, active high), bus_if (slave side of fence_sequencer_if).
module fence_sequencer
   import fence_sequencer_pkg::*;
#(
   parameter bit          DCACHE_SUPPORTED  = 1'b1,
   parameter bit          ICACHE_SUPPORTED  = 1'b1,
   parameter bit          VIRTMEM_SUPPORTED = 1'b1,
   parameter int unsigned TIMEOUT           = FENCE_TIMEOUT_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   fence_sequencer_if.slave   bus_if
);

   fence_state_t state_q, state_d;
   fence_kind_t  kind_q, kind_d;
   logic         timeout_q, timeout_d;

   logic req;
   logic wd_clr, wd_en, wd_expire;
   logic drain_exit, flush_exit;
   fence_state_t post_drain, post_dflush;

   logic flush_dcache, inval_icache, flush_tlb, fence_stall, fence_done;

   // A trapping fence never starts; reset also masks it so outputs stay low.
   assign req = (bus_if.FenceM | bus_if.FenceIM | bus_if.SFenceVmaM) & ~bus_if.TrapM & ~reset;

   assign drain_exit = ~bus_if.LSUBusyM | wd_expire;
   assign flush_exit = bus_if.DCacheFlushDoneM | wd_expire;

   // Every state change restarts the watchdog so each wait is timed on its own.
   assign wd_clr = (state_d != state_q);
   assign wd_en  = (state_q == DRAIN) || (state_q == DFLUSH) || (state_q == ABORT);

   fence_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (wd_clr),
      .en_i     (wd_en),
      .expire_o (wd_expire)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         kind_q    <= FENCE;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         kind_q    <= kind_d;
         timeout_q <= timeout_d;
      end
   end

   // Next-state logic.
   always_comb begin
      post_drain = DONE;
      if (kind_q == FENCEI) begin
         if (DCACHE_SUPPORTED)
            post_drain = DFLUSH;
         else if (ICACHE_SUPPORTED)
            post_drain = IINV;
      end else if ((kind_q == SFENCEVMA) && VIRTMEM_SUPPORTED) begin
         post_drain = TLB;
      end

      post_dflush = ICACHE_SUPPORTED ? IINV : DONE;

      state_d   = state_q;
      kind_d    = kind_q;
      timeout_d = timeout_q;

      case (state_q)
         IDLE: begin
            if (req) begin
               state_d = DRAIN;
               kind_d  = decode_kind(bus_if.FenceIM, bus_if.SFenceVmaM);
            end
         end
         DRAIN: begin
            if (bus_if.TrapM) begin
               state_d = IDLE;
            end else if (drain_exit) begin
               state_d = post_drain;
               // Only flag the watchdog when it, not the LSU, ended the wait.
               if (bus_if.LSUBusyM)
                  timeout_d = 1'b1;
            end
         end
         DFLUSH: begin
            if (bus_if.TrapM) begin
               // A flush finishing in the trap cycle leaves nothing to wait
               // for; otherwise the D$ FSM must be allowed to complete.
               state_d = bus_if.DCacheFlushDoneM ? IDLE : ABORT;
            end else if (flush_exit) begin
               state_d = post_dflush;
               if (!bus_if.DCacheFlushDoneM)
                  timeout_d = 1'b1;
            end
         end
         IINV, TLB: begin
            state_d = bus_if.TrapM ? IDLE : DONE;
         end
         DONE: begin
            if (bus_if.TrapM || !bus_if.StallW)
               state_d = IDLE;
         end
         ABORT: begin
            if (flush_exit)
               state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output logic.
   always_comb begin
      flush_dcache = 1'b0;
      inval_icache = 1'b0;
      flush_tlb    = 1'b0;
      fence_stall  = 1'b0;
      fence_done   = 1'b0;

      case (state_q)
         IDLE: begin
            // Hold the fence in M from the very cycle it is seen.
            fence_stall = req;
         end
         DRAIN: begin
            fence_stall = 1'b1;
         end
         DFLUSH: begin
            fence_stall  = 1'b1;
            flush_dcache = 1'b1;
         end
         IINV: begin
            fence_stall  = 1'b1;
            inval_icache = 1'b1;
         end
         TLB: begin
            fence_stall = 1'b1;
            flush_tlb   = 1'b1;
         end
         DONE: begin
            fence_done = ~bus_if.TrapM;
         end
         ABORT: begin
            flush_dcache = 1'b1;
         end
         default: begin
            fence_stall = 1'b0;
         end
      endcase
   end

   assign bus_if.FlushDCacheM      = flush_dcache;
   assign bus_if.InvalidateICacheM = inval_icache;
   assign bus_if.FlushTLBM         = flush_tlb;
   assign bus_if.FenceStallM       = fence_stall;
   assign bus_if.FenceDoneM        = fence_done;
   assign bus_if.FenceTimeoutM     = timeout_q;

endmodule

// File: tb/tb_fence_sequencer.sv
// Self-checking bench for fence_sequencer: three configurations, scoreboard of per-case totals.
// Latency: n/a.
// Backpressure: StallW and D$/LSU responses come from small reactive environment models.
module tb_fence_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset = 1'b1;

   // Pipeline-side drives (owned by the stimulus process).
   logic fence_m    = 1'b0;
   logic fencei_m   = 1'b0;
   logic sfence_m   = 1'b0;
   logic trap_req_m = 1'b0;
   int   sel        = 0;
   int   lsu_cfg    = 0;
   int   go_seq     = 0;
   int   dc_lat     = 0;
   int   stw_n      = 0;
   int   trap_at    = 0;

   // Environment-model drives (owned by the environment process).
   logic trap_m   = 1'b0;
   logic stall_w  = 1'b0;
   logic lsu_busy = 1'b0;
   logic dc_done  = 1'b0;
   int   seen_seq = 0;
   int   lsu_left = 0;
   int   dc_cnt   = 0;
   int   stw_cnt  = 0;

   fence_sequencer_if if0 ();
   fence_sequencer_if if1 ();
   fence_sequencer_if if2 ();

   fence_sequencer #(
      .DCACHE_SUPPORTED (1'b1), .ICACHE_SUPPORTED (1'b1),
      .VIRTMEM_SUPPORTED(1'b1), .TIMEOUT (1023)
   ) dut0 (.clk(clk), .reset(reset), .bus_if(if0));

   fence_sequencer #(
      .DCACHE_SUPPORTED (1'b1), .ICACHE_SUPPORTED (1'b1),
      .VIRTMEM_SUPPORTED(1'b1), .TIMEOUT (4)
   ) dut1 (.clk(clk), .reset(reset), .bus_if(if1));

   fence_sequencer #(
      .DCACHE_SUPPORTED (1'b0), .ICACHE_SUPPORTED (1'b0),
      .VIRTMEM_SUPPORTED(1'b0), .TIMEOUT (1023)
   ) dut2 (.clk(clk), .reset(reset), .bus_if(if2));

   // Opcodes reach only the selected instance; the rest stay idle.
   assign if0.FenceM = fence_m & (sel == 0);
   assign if0.FenceIM = fencei_m & (sel == 0);
   assign if0.SFenceVmaM = sfence_m & (sel == 0);
   assign if1.FenceM = fence_m & (sel == 1);
   assign if1.FenceIM = fencei_m & (sel == 1);
   assign if1.SFenceVmaM = sfence_m & (sel == 1);
   assign if2.FenceM = fence_m & (sel == 2);
   assign if2.FenceIM = fencei_m & (sel == 2);
   assign if2.SFenceVmaM = sfence_m & (sel == 2);

   assign if0.TrapM = trap_m;   assign if1.TrapM = trap_m;   assign if2.TrapM = trap_m;
   assign if0.StallW = stall_w; assign if1.StallW = stall_w; assign if2.StallW = stall_w;
   assign if0.LSUBusyM = lsu_busy; assign if1.LSUBusyM = lsu_busy; assign if2.LSUBusyM = lsu_busy;
   assign if0.DCacheFlushDoneM = dc_done;
   assign if1.DCacheFlushDoneM = dc_done;
   assign if2.DCacheFlushDoneM = dc_done;

   logic m_stall, m_flush, m_iinv, m_tlb, m_done, m_tmo;

   always_comb begin
      m_stall = if0.FenceStallM;  m_flush = if0.FlushDCacheM;
      m_iinv  = if0.InvalidateICacheM; m_tlb = if0.FlushTLBM;
      m_done  = if0.FenceDoneM;   m_tmo   = if0.FenceTimeoutM;
      if (sel == 1) begin
         m_stall = if1.FenceStallM;  m_flush = if1.FlushDCacheM;
         m_iinv  = if1.InvalidateICacheM; m_tlb = if1.FlushTLBM;
         m_done  = if1.FenceDoneM;   m_tmo   = if1.FenceTimeoutM;
      end else if (sel == 2) begin
         m_stall = if2.FenceStallM;  m_flush = if2.FlushDCacheM;
         m_iinv  = if2.InvalidateICacheM; m_tlb = if2.FlushTLBM;
         m_done  = if2.FenceDoneM;   m_tmo   = if2.FenceTimeoutM;
      end
   end

   function automatic int outs_of(input int inst);
      int v;
      case (inst)
         1: v = {if1.FlushDCacheM, if1.InvalidateICacheM, if1.FlushTLBM,
                 if1.FenceStallM, if1.FenceDoneM, if1.FenceTimeoutM};
         2: v = {if2.FlushDCacheM, if2.InvalidateICacheM, if2.FlushTLBM,
                 if2.FenceStallM, if2.FenceDoneM, if2.FenceTimeoutM};
         default: v = {if0.FlushDCacheM, if0.InvalidateICacheM, if0.FlushTLBM,
                       if0.FenceStallM, if0.FenceDoneM, if0.FenceTimeoutM};
      endcase
      return v;
   endfunction

   // Environment: LSU busy countdown, D$ flush FSM with fixed latency (0 = never
   // finishes), a trap on a chosen flush cycle, and StallW held for stw_n DONE cycles.
   always @(posedge clk) begin
      #3;
      if (go_seq != seen_seq) begin
         seen_seq = go_seq;
         lsu_left = lsu_cfg;
      end else if (lsu_left > 0) begin
         lsu_left = lsu_left - 1;
      end
      lsu_busy = (lsu_left > 0);

      if (m_flush) begin
         dc_cnt  = dc_cnt + 1;
         dc_done = (dc_lat != 0) && (dc_cnt == dc_lat);
      end else begin
         dc_cnt  = 0;
         dc_done = 1'b0;
      end
      trap_m = trap_req_m | (m_flush && (trap_at != 0) && (dc_cnt == trap_at));

      if (m_done && (stw_cnt < stw_n)) begin
         stall_w = 1'b1;
         stw_cnt = stw_cnt + 1;
      end else begin
         stall_w = 1'b0;
         if (!m_done)
            stw_cnt = 0;
      end
   end

   // Cycle totals of the selected instance, sampled mid-cycle.
   int c_stall = 0, c_flush = 0, c_iinv = 0, c_tlb = 0, c_done = 0, c_both = 0;
   always @(negedge clk) begin
      if (m_stall) c_stall++;
      if (m_flush) c_flush++;
      if (m_iinv)  c_iinv++;
      if (m_tlb)   c_tlb++;
      if (m_done)  c_done++;
      if (m_stall && m_done) c_both++;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp)
         n_pass++;
      else
         $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
   endtask

   typedef struct {
      string name;
      int det, stall, flush, iinv, tlb, done, both, tmo;
   } exp_t;

   exp_t sb_q[$];

   function automatic exp_t mk(input string name, input int det, input int stall,
                               input int flush, input int iinv, input int tlb,
                               input int done, input int tmo);
      exp_t e;
      e.name = name; e.det = det; e.stall = stall; e.flush = flush;
      e.iinv = iinv; e.tlb = tlb; e.done = done; e.both = 0; e.tmo = tmo;
      return e;
   endfunction

   // kind: 0 FENCE, 1 FENCE.I, 2 SFENCE.VMA
   task automatic run_case(input int inst, input int kind, input int lsu, input int lat,
                           input int stw, input int trap_cyc, input bit trap_req,
                           input exp_t e);
      int b_stall, b_flush, b_iinv, b_tlb, b_done, b_both;
      int det, quiet, cyc;
      exp_t x;
      sel = inst; dc_lat = lat; stw_n = stw; trap_at = trap_cyc;
      sb_q.push_back(e);
      b_stall = c_stall; b_flush = c_flush; b_iinv = c_iinv;
      b_tlb = c_tlb; b_done = c_done; b_both = c_both;

      @(posedge clk); #1;
      fence_m = (kind == 0); fencei_m = (kind == 1); sfence_m = (kind == 2);
      trap_req_m = trap_req; lsu_cfg = lsu; go_seq++;
      @(negedge clk);
      det = int'(m_stall);
      @(posedge clk); #1;
      fence_m = 1'b0; fencei_m = 1'b0; sfence_m = 1'b0; trap_req_m = 1'b0;

      quiet = 0; cyc = 0;
      while (quiet < 4 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (!(m_stall || m_flush || m_iinv || m_tlb || m_done)) quiet++;
         else quiet = 0;
      end

      x = sb_q.pop_front();
      check($sformatf("%s.detect_stall", x.name), det, x.det);
      check($sformatf("%s.returned_idle", x.name), quiet, 4);
      check($sformatf("%s.stall_cycles", x.name), c_stall - b_stall, x.stall);
      check($sformatf("%s.dflush_cycles", x.name), c_flush - b_flush, x.flush);
      check($sformatf("%s.iinv_cycles", x.name), c_iinv - b_iinv, x.iinv);
      check($sformatf("%s.tlb_cycles", x.name), c_tlb - b_tlb, x.tlb);
      check($sformatf("%s.done_cycles", x.name), c_done - b_done, x.done);
      check($sformatf("%s.stall_with_done", x.name), c_both - b_both, x.both);
      check($sformatf("%s.timeout_flag", x.name), int'(m_tmo), x.tmo);
   endtask

   initial begin
      #500000;
      $display("FAIL global_time_limit: observed simulation still running, expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset.outs_inst0", outs_of(0), 0);
      check("reset.outs_inst1", outs_of(1), 0);
      check("reset.outs_inst2", outs_of(2), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);

      //       inst kind lsu lat stw trap treq       det stall flush iinv tlb done tmo
      run_case(0, 1, 3, 5, 0, 0, 1'b0, mk("fencei_busy",   1, 10, 5, 1, 0, 1, 0));
      run_case(0, 2, 0, 0, 0, 0, 1'b0, mk("sfence_idle",   1,  3, 0, 0, 1, 1, 0));
      run_case(0, 0, 0, 0, 2, 0, 1'b0, mk("fence_stallw",  1,  2, 0, 0, 0, 3, 0));
      run_case(0, 1, 0, 5, 0, 2, 1'b0, mk("trap_dflush",   1,  4, 5, 0, 0, 0, 0));
      run_case(0, 0, 0, 0, 0, 0, 1'b1, mk("trap_on_req",   0,  0, 0, 0, 0, 0, 0));
      run_case(1, 1, 0, 0, 0, 0, 1'b0, mk("wd_dflush",     1,  7, 4, 1, 0, 1, 1));
      run_case(1, 0, 20, 0, 0, 0, 1'b0, mk("wd_drain",     1,  5, 0, 0, 0, 1, 1));
      run_case(2, 1, 0, 0, 0, 0, 1'b0, mk("nocache_fencei", 1, 2, 0, 0, 0, 1, 0));
      run_case(2, 2, 0, 0, 0, 0, 1'b0, mk("nommu_sfence",  1,  2, 0, 0, 0, 1, 0));

      // Reset landing mid-DFLUSH: everything, including the sticky flag, drops.
      sel = 0; dc_lat = 0; stw_n = 0; trap_at = 0;
      @(posedge clk); #1;
      fencei_m = 1'b1; lsu_cfg = 0; go_seq++;
      @(posedge clk); #1;
      fencei_m = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("midreset.flush_active", int'(m_flush), 1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("midreset.outs_inst0", outs_of(0), 0);
      check("midreset.timeout_cleared_inst1", outs_of(1), 0);
      repeat (3) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
